// File: rtl/draw_scheduler_pkg.sv
// Shared types and constants for the draw scheduler: FSM encoding, VGA field
// widths, default sizing, and the next-set-bit client selector.
package draw_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_ERASE_START = 3'd1,
        S_ERASE_WAIT  = 3'd2,
        S_MOVE        = 3'd3,
        S_DRAW_START  = 3'd4,
        S_DRAW_WAIT   = 3'd5
    } state_t;

    localparam logic [2:0] BLACK       = 3'b000;
    localparam int         VGA_XW      = 8;
    localparam int         VGA_YW      = 7;
    localparam int         DEF_NCLIENT = 3;
    localparam int         DEF_TIMEOUT = 1024;

    // Selector works on a fixed-width mask; SEL_NONE means "no bit found".
    localparam int                MAX_CLIENT = 16;
    localparam int                SEL_W      = 5;
    localparam logic [SEL_W-1:0]  SEL_NONE   = SEL_W'(MAX_CLIENT);

    function automatic logic [SEL_W-1:0] next_set_bit(
        input logic [MAX_CLIENT-1:0] mask,
        input logic [SEL_W-1:0]      from
    );
        logic [SEL_W-1:0] sel;
        sel = SEL_NONE;
        for (int i = MAX_CLIENT - 1; i >= 0; i--) begin
            if (mask[i] && (SEL_W'(i) >= from)) begin
                sel = SEL_W'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/draw_scheduler_watchdog.sv
// Per-client wait watchdog: counts WAIT cycles and flags the terminal count
// so a client that never reports done cannot stall the frame.
module draw_watchdog
    import draw_scheduler_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !tc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tc = (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/draw_scheduler.sv
// Frame scheduler: per frame, erases each enabled client in index order,
// pulses a position update, then redraws them, muxing the shared VGA plot port.
module draw_scheduler
    import draw_scheduler_pkg::*;
#(
    parameter int NCLIENT = DEF_NCLIENT,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame_tick,
    input  logic [NCLIENT-1:0]      client_en,
    input  logic [NCLIENT-1:0]      done,
    input  logic [NCLIENT*10-1:0]   cx,
    input  logic [NCLIENT*10-1:0]   cy,
    input  logic [NCLIENT*3-1:0]    ccolour,
    input  logic [NCLIENT-1:0]      cwren,
    output logic [NCLIENT-1:0]      draw,
    output logic [NCLIENT-1:0]      move_en,
    output logic [VGA_XW-1:0]       vga_x,
    output logic [VGA_YW-1:0]       vga_y,
    output logic [2:0]              vga_colour,
    output logic                    vga_plot,
    output logic                    busy,
    output logic                    overrun,
    output logic                    timeout_err
);

    localparam int IDXW = (NCLIENT > 1) ? $clog2(NCLIENT) : 1;

    state_t              r_state;
    logic [IDXW-1:0]     r_idx;
    logic [NCLIENT-1:0]  r_frame_mask;
    logic                r_pending;
    logic                r_overrun;
    logic                r_timeout_err;
    logic [VGA_XW-1:0]   r_vga_x;
    logic [VGA_YW-1:0]   r_vga_y;
    logic [2:0]          r_vga_colour;
    logic                r_vga_plot;

    state_t              w_state_next;
    logic [IDXW-1:0]     w_idx_next;
    logic [NCLIENT-1:0]  w_frame_mask_next;
    logic                w_pending_next;
    logic                w_overrun_next;
    logic                w_timeout_err_next;

    logic [VGA_XW-1:0]   w_cx     [NCLIENT];
    logic [VGA_YW-1:0]   w_cy     [NCLIENT];
    logic [2:0]          w_colour [NCLIENT];

    logic [SEL_W-1:0]    w_first_en;
    logic [SEL_W-1:0]    w_first_mask;
    logic [SEL_W-1:0]    w_next_sel;
    logic                w_in_wait;
    logic                w_wd_tc;
    logic                w_advance;
    logic                w_start;
    logic [NCLIENT-1:0]  w_draw;
    logic [NCLIENT-1:0]  w_move_en;
    logic                w_busy;

    // Only the low VGA-width bits of each coordinate reach the port; the rest
    // are deliberately dropped (truncation, not clamping).
    for (genvar gi = 0; gi < NCLIENT; gi++) begin : g_unpack
        assign w_cx[gi]     = cx[gi*10 +: VGA_XW];
        assign w_cy[gi]     = cy[gi*10 +: VGA_YW];
        assign w_colour[gi] = ccolour[gi*3 +: 3];
    end

    logic w_unused_bits;
    assign w_unused_bits = &{1'b0, cx, cy, w_first_en, w_first_mask, w_next_sel};

    assign w_first_en   = next_set_bit(MAX_CLIENT'(client_en), '0);
    assign w_first_mask = next_set_bit(MAX_CLIENT'(r_frame_mask), '0);
    assign w_next_sel   = next_set_bit(MAX_CLIENT'(r_frame_mask), SEL_W'(r_idx) + 1'b1);

    assign w_in_wait = (r_state == S_ERASE_WAIT) || (r_state == S_DRAW_WAIT);
    assign w_start   = frame_tick || r_pending;
    assign w_advance = w_in_wait && (done[r_idx] || w_wd_tc);

    draw_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (!w_in_wait),
        .enable (w_in_wait),
        .tc     (w_wd_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_frame_mask  <= '0;
            r_pending     <= 1'b0;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_idx         <= w_idx_next;
            r_frame_mask  <= w_frame_mask_next;
            r_pending     <= w_pending_next;
            r_overrun     <= w_overrun_next;
            r_timeout_err <= w_timeout_err_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_idx_next         = r_idx;
        w_frame_mask_next  = r_frame_mask;
        w_pending_next     = r_pending;
        w_overrun_next     = r_overrun;
        w_timeout_err_next = r_timeout_err;

        // A tick while busy is remembered once; extra ticks just fold in.
        if ((r_state != S_IDLE) && frame_tick) begin
            w_overrun_next = 1'b1;
            w_pending_next = 1'b1;
        end
        if (w_advance && w_wd_tc) begin
            w_timeout_err_next = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_frame_mask_next = client_en;
                    w_pending_next    = 1'b0;
                    if (client_en == '0) begin
                        w_idx_next   = '0;
                        w_state_next = S_MOVE;
                    end else begin
                        w_idx_next   = w_first_en[IDXW-1:0];
                        w_state_next = S_ERASE_START;
                    end
                end
            end
            S_ERASE_START: w_state_next = S_ERASE_WAIT;
            S_ERASE_WAIT: begin
                if (w_advance) begin
                    if (w_next_sel != SEL_NONE) begin
                        w_idx_next   = w_next_sel[IDXW-1:0];
                        w_state_next = S_ERASE_START;
                    end else begin
                        w_state_next = S_MOVE;
                    end
                end
            end
            S_MOVE: begin
                if (r_frame_mask == '0) begin
                    w_idx_next   = '0;
                    w_state_next = S_IDLE;
                end else begin
                    w_idx_next   = w_first_mask[IDXW-1:0];
                    w_state_next = S_DRAW_START;
                end
            end
            S_DRAW_START: w_state_next = S_DRAW_WAIT;
            S_DRAW_WAIT: begin
                if (w_advance) begin
                    if (w_next_sel != SEL_NONE) begin
                        w_idx_next   = w_next_sel[IDXW-1:0];
                        w_state_next = S_DRAW_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_draw    = '0;
        w_move_en = '0;
        w_busy    = (r_state != S_IDLE);
        if ((r_state == S_ERASE_START) || (r_state == S_DRAW_START)) begin
            w_draw[r_idx] = 1'b1;
        end
        if (r_state == S_MOVE) begin
            w_move_en = r_frame_mask;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= BLACK;
            r_vga_plot   <= 1'b0;
        end else if (w_in_wait) begin
            r_vga_x      <= w_cx[r_idx];
            r_vga_y      <= w_cy[r_idx];
            r_vga_colour <= (r_state == S_ERASE_WAIT) ? BLACK : w_colour[r_idx];
            r_vga_plot   <= cwren[r_idx];
        end else begin
            r_vga_plot   <= 1'b0;
        end
    end

    assign draw        = w_draw;
    assign move_en     = w_move_en;
    assign busy        = w_busy;
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout_err;
    assign vga_x       = r_vga_x;
    assign vga_y       = r_vga_y;
    assign vga_colour  = r_vga_colour;
    assign vga_plot    = r_vga_plot;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler with behavioural clients that answer
// draw pulses with done five cycles later unless muted.
module tb_draw_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic [2:0]  client_en;
    logic [2:0]  done;
    logic [29:0] cx;
    logic [29:0] cy;
    logic [8:0]  ccolour;
    logic [2:0]  cwren;
    logic [2:0]  draw;
    logic [2:0]  move_en;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        busy;
    logic        overrun;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;

    logic [2:0]  mute = 3'b000;
    logic [31:0] draw_word = '0;
    logic [31:0] move_word = '0;
    int          draw_n = 0;
    int          move_n = 0;

    draw_scheduler #(
        .NCLIENT (3),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .client_en   (client_en),
        .done        (done),
        .cx          (cx),
        .cy          (cy),
        .ccolour     (ccolour),
        .cwren       (cwren),
        .draw        (draw),
        .move_en     (move_en),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Client responders: done pulses five cycles after the draw pulse.
    initial begin
        int cnt [3];
        done = 3'b000;
        for (int i = 0; i < 3; i++) cnt[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (draw[i] === 1'b1) begin
                    cnt[i]  = 5;
                    done[i] = 1'b0;
                end else if (cnt[i] > 0) begin
                    cnt[i]  = cnt[i] - 1;
                    done[i] = (cnt[i] == 0) && !mute[i];
                end else begin
                    done[i] = 1'b0;
                end
            end
        end
    end

    // Pulse history: one nibble per cycle in which draw / move_en is nonzero.
    initial begin
        forever begin
            @(negedge clk);
            if (draw !== 3'b000) begin
                draw_word = {draw_word[27:0], 1'b0, draw};
                draw_n    = draw_n + 1;
            end
            if (move_en !== 3'b000) begin
                move_word = {move_word[27:0], 1'b0, move_en};
                move_n    = move_n + 1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic wait_busy(input logic level, input int bound, output bit ok);
        int i;
        i = 0;
        while ((busy !== level) && (i < bound)) begin
            @(negedge clk);
            i++;
        end
        ok = (busy === level);
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        frame_tick = 1'b0;
        client_en  = 3'b000;
        cx         = '0;
        cy         = '0;
        ccolour    = '0;
        cwren      = '0;
        step(3);
        checks++;
        if ({draw, move_en} !== 6'b0) begin
            errors++;
            $display("FAIL reset_pulses: got %b expected 000000", {draw, move_en});
        end
        checks++;
        if ({vga_plot, vga_colour, vga_x, vga_y} !== 19'b0) begin
            errors++;
            $display("FAIL reset_vga: got %h expected 0", {vga_plot, vga_colour, vga_x, vga_y});
        end
        checks++;
        if ({busy, overrun, timeout_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_status: got %b expected 000", {busy, overrun, timeout_err});
        end
        reset = 1'b0;
        step(4);
        checks++;
        if ({busy, draw} !== 4'b0) begin
            errors++;
            $display("FAIL reset_quiet: got %b expected 0000", {busy, draw});
        end
        $display("test_reset done");
    endtask

    task automatic test_full_frame();
        int bd, bm;
        bit ok;
        client_en = 3'b111;
        mute      = 3'b000;
        bd = draw_n;
        bm = move_n;
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL full_busy_rise: got %b expected 1", busy);
        end
        wait_busy(1'b0, 200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL full_busy_fall: got busy=%b expected 0 within 200 cycles", busy);
        end
        step(2);
        checks++;
        if ((draw_n - bd) != 6 || draw_word[23:0] !== 24'h124124) begin
            errors++;
            $display("FAIL full_draw_order: got n=%0d seq=%h expected n=6 seq=124124", draw_n - bd, draw_word[23:0]);
        end
        checks++;
        if ((move_n - bm) != 1 || move_word[3:0] !== 4'h7) begin
            errors++;
            $display("FAIL full_move: got n=%0d val=%h expected n=1 val=7", move_n - bm, move_word[3:0]);
        end
        checks++;
        if ({overrun, timeout_err} !== 2'b00) begin
            errors++;
            $display("FAIL full_flags: got %b expected 00", {overrun, timeout_err});
        end
        $display("test_full_frame done");
    endtask

    task automatic test_plot();
        int i;
        bit ok;
        client_en = 3'b010;
        cwren     = 3'b010;
        cx        = {10'd0, 10'd40, 10'd0};
        cy        = {10'd0, 10'd20, 10'd0};
        ccolour   = {3'b000, 3'b100, 3'b000};
        tick();
        checks++;
        if (draw !== 3'b010) begin
            errors++;
            $display("FAIL plot_erase_draw: got %b expected 010", draw);
        end
        step(1);
        checks++;
        if (vga_plot !== 1'b0) begin
            errors++;
            $display("FAIL plot_start_gap: got %b expected 0", vga_plot);
        end
        step(1);
        checks++;
        if ({vga_plot, vga_colour, vga_x, vga_y} !== {1'b1, 3'b000, 8'd40, 7'd20}) begin
            errors++;
            $display("FAIL plot_erase: got p=%b c=%b x=%0d y=%0d expected p=1 c=000 x=40 y=20",
                     vga_plot, vga_colour, vga_x, vga_y);
        end
        cx = {10'd0, 10'd300, 10'd0};
        cy = {10'd0, 10'd200, 10'd0};
        i = 0;
        while ((move_en === 3'b000) && (i < 50)) begin
            step(1);
            i++;
        end
        step(1);
        checks++;
        if (draw !== 3'b010) begin
            errors++;
            $display("FAIL plot_draw_start: got %b expected 010", draw);
        end
        step(2);
        checks++;
        if ({vga_plot, vga_colour, vga_x, vga_y} !== {1'b1, 3'b100, 8'd44, 7'd72}) begin
            errors++;
            $display("FAIL plot_draw: got p=%b c=%b x=%0d y=%0d expected p=1 c=100 x=44 y=72",
                     vga_plot, vga_colour, vga_x, vga_y);
        end
        wait_busy(1'b0, 100, ok);
        step(1);
        checks++;
        if (!ok || vga_plot !== 1'b0) begin
            errors++;
            $display("FAIL plot_idle: got ok=%b plot=%b expected ok=1 plot=0", ok, vga_plot);
        end
        cwren = 3'b000;
        $display("test_plot done");
    endtask

    task automatic test_mask();
        int bd, bm;
        bit ok;
        client_en = 3'b101;
        bd = draw_n;
        bm = move_n;
        tick();
        wait_busy(1'b0, 200, ok);
        step(2);
        checks++;
        if (!ok || (draw_n - bd) != 4 || draw_word[15:0] !== 16'h1414) begin
            errors++;
            $display("FAIL mask_draw: got ok=%b n=%0d seq=%h expected ok=1 n=4 seq=1414", ok, draw_n - bd, draw_word[15:0]);
        end
        checks++;
        if ((move_n - bm) != 1 || move_word[3:0] !== 4'h5) begin
            errors++;
            $display("FAIL mask_move: got n=%0d val=%h expected n=1 val=5", move_n - bm, move_word[3:0]);
        end
        $display("test_mask done");
    endtask

    task automatic test_timeout();
        int   i;
        logic te_before;
        bit   ok;
        mute      = 3'b100;
        client_en = 3'b100;
        tick();
        checks++;
        if (draw !== 3'b100) begin
            errors++;
            $display("FAIL to_draw: got %b expected 100", draw);
        end
        i = 0;
        te_before = 1'bx;
        while ((move_en === 3'b000) && (i < 40)) begin
            te_before = timeout_err;
            step(1);
            i++;
        end
        checks++;
        if (i != 17) begin
            errors++;
            $display("FAIL to_gap: got %0d cycles draw->move expected 17", i);
        end
        checks++;
        if (te_before !== 1'b0 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL to_flag_edge: got before=%b after=%b expected 0 then 1", te_before, timeout_err);
        end
        wait_busy(1'b0, 100, ok);
        mute      = 3'b000;
        client_en = 3'b001;
        step(1);
        tick();
        wait_busy(1'b0, 100, ok);
        step(1);
        checks++;
        if (!ok || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL to_sticky: got ok=%b err=%b expected ok=1 err=1", ok, timeout_err);
        end
        $display("test_timeout done");
    endtask

    task automatic test_overrun();
        int bd, cnt;
        bit ok;
        client_en = 3'b001;
        bd = draw_n;
        tick();
        step(2);
        tick();
        step(1);
        tick();
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_flag: got %b expected 1", overrun);
        end
        wait_busy(1'b0, 100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ovr_idle: got busy=%b expected 0 within 100 cycles", busy);
        end
        step(1);
        checks++;
        if ({busy, draw} !== 4'b1001) begin
            errors++;
            $display("FAIL ovr_restart: got busy=%b draw=%b expected busy=1 draw=001", busy, draw);
        end
        step(1);
        wait_busy(1'b0, 100, ok);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            if (busy !== 1'b0) cnt++;
        end
        checks++;
        if (!ok || cnt != 0 || (draw_n - bd) != 4) begin
            errors++;
            $display("FAIL ovr_single_extra: got ok=%b busy_cycles=%0d draws=%0d expected ok=1 0 4", ok, cnt, draw_n - bd);
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sticky: got %b expected 1", overrun);
        end
        $display("test_overrun done");
    endtask

    task automatic test_reset_mid();
        int i, bd, bm;
        bit ok;
        client_en = 3'b111;
        cx        = {10'd9, 10'd8, 10'd7};
        cy        = {10'd3, 10'd2, 10'd1};
        cwren     = 3'b111;
        tick();
        i = 0;
        while ((move_en === 3'b000) && (i < 100)) begin
            step(1);
            i++;
        end
        step(3);
        reset = 1'b1;
        #1;
        checks++;
        if ({draw, move_en} !== 6'b0) begin
            errors++;
            $display("FAIL rmid_pulses: got %b expected 000000", {draw, move_en});
        end
        checks++;
        if ({vga_plot, vga_colour, vga_x, vga_y} !== 19'b0) begin
            errors++;
            $display("FAIL rmid_vga: got %h expected 0", {vga_plot, vga_colour, vga_x, vga_y});
        end
        checks++;
        if ({busy, overrun, timeout_err} !== 3'b000) begin
            errors++;
            $display("FAIL rmid_status: got %b expected 000", {busy, overrun, timeout_err});
        end
        step(2);
        reset = 1'b0;
        bd = draw_n;
        bm = move_n;
        step(30);
        checks++;
        if ((draw_n - bd) != 0 || (move_n - bm) != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_quiet: got draws=%0d moves=%0d busy=%b expected 0 0 0", draw_n - bd, move_n - bm, busy);
        end
        tick();
        wait_busy(1'b0, 200, ok);
        step(2);
        checks++;
        if (!ok || (draw_n - bd) != 6) begin
            errors++;
            $display("FAIL rmid_new_frame: got ok=%b draws=%0d expected ok=1 draws=6", ok, draw_n - bd);
        end
        cwren = 3'b000;
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_plot();
        test_mask();
        test_timeout();
        test_overrun();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/draw_scheduler.md
DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 SHALL have parameter NCLIENT, default 3, meaning number of drawable objects (0=platform, 1=ball, 2=bricks).
REQ-002 SHALL have parameter TIMEOUT, default 1024, meaning max cycles to wait for a client done.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 frame_tick  input  1  one-cycle pulse per video frame; starts an update cycle.
REQ-006 client_en  input  NCLIENT  per-client participation mask, sampled at frame start.
REQ-007 done  input  NCLIENT  per-client pulse: the client's draw sweep finished.
REQ-008 cx, cy  input  NCLIENT*10 each  per-client pixel coordinates, packed, client i at bits [10i+9:10i].
REQ-009 ccolour  input  NCLIENT*3  per-client pixel colour, packed.
REQ-010 cwren  input  NCLIENT  per-client write enable.
REQ-011 draw  output  NCLIENT  one-cycle start pulse to the selected client.
REQ-012 move_en  output  NCLIENT  one-cycle position-update pulse to enabled clients.
REQ-013 vga_x  output 8, vga_y  output 7, vga_colour  output 3, vga_plot  output 1  shared VGA plot port.
REQ-014 busy, overrun, timeout_err  output  1 each  status flags.

Function
REQ-015 FSM states SHALL be IDLE, ERASE_START, ERASE_WAIT, MOVE, DRAW_START, DRAW_WAIT.
REQ-016 IDLE -> ERASE_START on frame_tick or pending; latch client_en into frame_mask; client index idx := lowest set bit of frame_mask.
REQ-017 frame_mask == 0 at start: IDLE -> MOVE -> IDLE; no draw pulses issued.
REQ-018 ERASE_START/DRAW_START: assert draw[idx] for exactly one cycle, clear watchdog, go to matching WAIT.
REQ-019 WAIT states: done[idx] ignored during the START cycle; accepted from the first WAIT cycle.
REQ-020 WAIT on done[idx] or watchdog == TIMEOUT-1: advance idx to next set bit of frame_mask and return to START; after last set bit, ERASE_WAIT -> MOVE, DRAW_WAIT -> IDLE.
REQ-021 Watchdog expiry SHALL set sticky timeout_err; cleared only by reset.
REQ-022 MOVE: assert move_en = frame_mask for exactly one cycle, then DRAW_START at lowest set bit.
REQ-023 done bits of non-selected clients SHALL be ignored.
REQ-024 Plot port registered, 1-cycle latency: vga_x = cx[idx][7:0], vga_y = cy[idx][6:0], vga_plot = cwren[idx], all sampled in WAIT states only.
REQ-025 In ERASE_WAIT vga_colour SHALL be 3'b000; in DRAW_WAIT ccolour[idx].
REQ-026 Outside WAIT states vga_plot SHALL be 0 on the next cycle.
REQ-027 busy = 1 in every state except IDLE.
REQ-028 frame_tick while busy SHALL set sticky overrun and a 1-deep pending bit; further ticks while pending set are dropped.
REQ-029 pending SHALL clear when IDLE consumes it; frame_tick and pending in the same IDLE cycle start a single frame.
REQ-030 cx/cy above 159/119 SHALL be passed truncated, not clamped.

Reset
REQ-031 Reset SHALL force state IDLE, idx 0, frame_mask 0, pending 0, watchdog 0.
REQ-032 Reset SHALL force draw, move_en, vga_x, vga_y, vga_colour, vga_plot, busy, overrun and timeout_err to 0.
REQ-033 Reset mid-frame SHALL abandon the frame; no draw or move_en pulse follows deassertion without a new frame_tick.

Structure
REQ-034 Shared package SHALL hold state encoding, BLACK = 3'b000, VGA_XW = 8, VGA_YW = 7 and default NCLIENT/TIMEOUT.
REQ-035 Watchdog counter SHALL be sub-module draw_watchdog (clear, enable, terminal-count output).
REQ-036 Next-set-bit selection SHALL be a combinational function in the package.

Verification
REQ-037 client_en=3'b111, each client raises done 5 cycles after draw -> draw order 0,1,2 erase, move_en=3'b111 one cycle, draw order 0,1,2; busy falls after final done.
REQ-038 During erase client 1 drives cwren=1, ccolour=3'b100, cx=40 -> next cycle vga_plot=1, vga_colour=000, vga_x=40; same stimulus in draw -> vga_colour=100.
REQ-039 client_en=3'b101 -> client 1 never receives draw or move_en; move_en=3'b101.
REQ-040 Client 2 never asserts done, TIMEOUT=16 -> advances after 16 WAIT cycles, timeout_err=1 and stays 1.
REQ-041 Two frame_ticks during a busy frame -> overrun=1; exactly one extra frame runs, starting the cycle after IDLE.
REQ-042 reset pulsed in DRAW_WAIT -> all outputs 0; no draw pulse until next frame_tick.
